// File: rtl/rf_wb_pkg.sv
// rf_wb_pkg: shared definitions for the register-file writeback path.
//   REG_W   - register index width
//   DATA_W  - register data width
//   ld_whb_e - load width/sign codes, shared with the datapath control decoder
package rf_wb_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam int NREGS  = 32;

  typedef enum logic [2:0] {
    LD_LW  = 3'd0,
    LD_LH  = 3'd1,
    LD_LHU = 3'd2,
    LD_LB  = 3'd3,
    LD_LBU = 3'd4
  } ld_whb_e;

endpackage

// File: rtl/rf_ld_extract.sv
// rf_ld_extract: combinational load-data alignment and extension.
// Ports:
//   word  (in, 32) raw memory word
//   whb   (in, 3)  load width/sign code (ld_whb_e); unknown codes act as LW
//   addr  (in, 2)  byte offset within the word
//   value (out, 32) aligned, sign/zero-extended result
module rf_ld_extract
  import rf_wb_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [2:0]        whb,
  input  logic [1:0]        addr,
  output logic [DATA_W-1:0] value
);

  logic [15:0] half_s;
  logic [7:0]  byte_s;

  // Select the addressed half-word and byte lanes.
  always_comb begin
    half_s = word[15:0];
    byte_s = word[7:0];
    if (addr[1]) begin
      half_s = word[31:16];
    end else begin
      half_s = word[15:0];
    end
    case (addr)
      2'd0:    byte_s = word[7:0];
      2'd1:    byte_s = word[15:8];
      2'd2:    byte_s = word[23:16];
      2'd3:    byte_s = word[31:24];
      default: byte_s = word[7:0];
    endcase
  end

  // Extend the selected lane according to the width/sign code.
  always_comb begin
    value = word;
    case (ld_whb_e'(whb))
      LD_LH:   value = {{16{half_s[15]}}, half_s};
      LD_LHU:  value = {16'h0000, half_s};
      LD_LB:   value = {{24{byte_s[7]}}, byte_s};
      LD_LBU:  value = {24'h000000, byte_s};
      default: value = word;
    endcase
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: arbitrates ALU and load writebacks onto one register-file
// write port and keeps a pending-write scoreboard for hazard checks.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   alu_vld/alu_rd/alu_data/alu_rdy ALU writeback requester
//   ld_vld/ld_rd/ld_data/ld_whb/ld_addr/ld_rdy load writeback requester
//   issue_vld/issue_rd             marks issue_rd as pending
//   chk_rs/chk_rt/stall            source-hazard query (combinational)
//   rf_we/rf_wa/rf_wd              registered register-file write port
//   busy                           pending-write scoreboard
// Configuration: define RF_WB_FAIR_EN to add a 2-bit age counter that lets a
// starved ALU request win over a load after three lost cycles. Without it,
// loads have strict priority.
module rf_wb_arbiter
  import rf_wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_vld,
  input  logic [REG_W-1:0]  alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_rdy,
  input  logic              ld_vld,
  input  logic [REG_W-1:0]  ld_rd,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [2:0]        ld_whb,
  input  logic [1:0]        ld_addr,
  output logic              ld_rdy,
  input  logic              issue_vld,
  input  logic [REG_W-1:0]  issue_rd,
  input  logic [REG_W-1:0]  chk_rs,
  input  logic [REG_W-1:0]  chk_rt,
  output logic              stall,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic [NREGS-1:0]  busy
);

  logic              ld_acc_s;
  logic              alu_acc_s;
  logic [DATA_W-1:0] ld_val_s;
  logic              we_nxt_s;
  logic [REG_W-1:0]  wa_nxt_s;
  logic [DATA_W-1:0] wd_nxt_s;
  logic [NREGS-1:0]  busy_nxt_s;
  logic              rf_we_r;
  logic [REG_W-1:0]  rf_wa_r;
  logic [DATA_W-1:0] rf_wd_r;
  logic [NREGS-1:0]  busy_r;

  rf_ld_extract u_ld_extract (
    .word  (ld_data),
    .whb   (ld_whb),
    .addr  (ld_addr),
    .value (ld_val_s)
  );

`ifdef RF_WB_FAIR_EN
  logic [1:0] age_r;
  logic [1:0] age_nxt_s;
  logic       fair_s;

  // Ready generation: a saturated age counter hands the slot to the ALU.
  always_comb begin
    fair_s  = alu_vld & (age_r == 2'd3);
    ld_rdy  = ld_vld & ~fair_s;
    alu_rdy = alu_vld & (~ld_vld | fair_s);
  end

  // Age counter next state: count lost ALU cycles, clear on grant or idle.
  always_comb begin
    age_nxt_s = age_r;
    if (!alu_vld || alu_rdy) begin
      age_nxt_s = 2'd0;
    end else if (age_r != 2'd3) begin
      age_nxt_s = age_r + 2'd1;
    end else begin
      age_nxt_s = age_r;
    end
  end

  // Age counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_r <= 2'd0;
    end else begin
      age_r <= age_nxt_s;
    end
  end
`else
  // Ready generation: strict load priority.
  always_comb begin
    ld_rdy  = ld_vld;
    alu_rdy = alu_vld & ~ld_vld;
  end
`endif

  // Select the accepted request; writes to r0 complete the handshake silently.
  always_comb begin
    ld_acc_s  = ld_vld & ld_rdy;
    alu_acc_s = alu_vld & alu_rdy;
    we_nxt_s  = 1'b0;
    wa_nxt_s  = rf_wa_r;
    wd_nxt_s  = rf_wd_r;
    if (ld_acc_s) begin
      we_nxt_s = (ld_rd != 5'd0);
      wa_nxt_s = ld_rd;
      wd_nxt_s = ld_val_s;
    end else if (alu_acc_s) begin
      we_nxt_s = (alu_rd != 5'd0);
      wa_nxt_s = alu_rd;
      wd_nxt_s = alu_data;
    end else begin
      we_nxt_s = 1'b0;
    end
  end

  // Scoreboard next state: clear on writeback first so a same-edge set wins.
  always_comb begin
    busy_nxt_s = busy_r;
    if (rf_we_r) begin
      busy_nxt_s[rf_wa_r] = 1'b0;
    end else begin
      busy_nxt_s = busy_r;
    end
    if (issue_vld && (issue_rd != 5'd0)) begin
      busy_nxt_s[issue_rd] = 1'b1;
    end else begin
      busy_nxt_s[issue_rd] = busy_nxt_s[issue_rd];
    end
    busy_nxt_s[0] = 1'b0;
  end

  // Write-port and scoreboard registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_r <= 1'b0;
      rf_wa_r <= 5'd0;
      rf_wd_r <= 32'h0000_0000;
      busy_r  <= 32'h0000_0000;
    end else begin
      rf_we_r <= we_nxt_s;
      rf_wa_r <= wa_nxt_s;
      rf_wd_r <= wd_nxt_s;
      busy_r  <= busy_nxt_s;
    end
  end

  // Hazard query reads the registered scoreboard only (no writeback bypass).
  always_comb begin
    stall = busy_r[chk_rs] | busy_r[chk_rt];
  end

  assign rf_we = rf_we_r;
  assign rf_wa = rf_wa_r;
  assign rf_wd = rf_wd_r;
  assign busy  = busy_r;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        alu_vld;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_rdy;
  logic        ld_vld;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic [2:0]  ld_whb;
  logic [1:0]  ld_addr;
  logic        ld_rdy;
  logic        issue_vld;
  logic [4:0]  issue_rd;
  logic [4:0]  chk_rs;
  logic [4:0]  chk_rt;
  logic        stall;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [31:0] busy;

  int total;
  int bad;

`ifdef RF_WB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  rf_wb_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_vld   (alu_vld),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_rdy   (alu_rdy),
    .ld_vld    (ld_vld),
    .ld_rd     (ld_rd),
    .ld_data   (ld_data),
    .ld_whb    (ld_whb),
    .ld_addr   (ld_addr),
    .ld_rdy    (ld_rdy),
    .issue_vld (issue_vld),
    .issue_rd  (issue_rd),
    .chk_rs    (chk_rs),
    .chk_rt    (chk_rt),
    .stall     (stall),
    .rf_we     (rf_we),
    .rf_wa     (rf_wa),
    .rf_wd     (rf_wd),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_vld = 1'b0; alu_rd = 5'd0; alu_data = 32'h0;
    ld_vld = 1'b0; ld_rd = 5'd0; ld_data = 32'h0; ld_whb = 3'd0; ld_addr = 2'd0;
    issue_vld = 1'b0; issue_rd = 5'd0; chk_rs = 5'd0; chk_rt = 5'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick(); tick();
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", rf_we); end
    total++; if (rf_wa !== 5'd0) begin bad++; $display("FAIL reset_wa got=%0d exp=0", rf_wa); end
    total++; if (rf_wd !== 32'h0) begin bad++; $display("FAIL reset_wd got=%h exp=0", rf_wd); end
    total++; if (busy !== 32'h0) begin bad++; $display("FAIL reset_busy got=%h exp=0", busy); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_extract();
    logic [2:0]  whb_t [7];
    logic [1:0]  addr_t [7];
    logic [31:0] exp_t [7];
    whb_t  = '{3'd3, 3'd2, 3'd1, 3'd4, 3'd3, 3'd0, 3'd7};
    addr_t = '{2'd2, 2'd2, 2'd0, 2'd1, 2'd3, 2'd1, 2'd2};
    exp_t  = '{32'hFFFFFF99, 32'h00008899, 32'hFFFFAABB, 32'h000000AA,
               32'hFFFFFF88, 32'h8899AABB, 32'h8899AABB};
    ld_data = 32'h8899AABB;
    for (int i = 0; i < 7; i++) begin
      ld_vld = 1'b1; ld_rd = 5'(5 + i); ld_whb = whb_t[i]; ld_addr = addr_t[i];
      #1;
      total++; if (ld_rdy !== 1'b1) begin bad++; $display("FAIL ld_rdy[%0d] got=%b exp=1", i, ld_rdy); end
      tick();
      total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL ld_we[%0d] got=%b exp=1", i, rf_we); end
      total++; if (rf_wa !== 5'(5 + i)) begin bad++; $display("FAIL ld_wa[%0d] got=%0d exp=%0d", i, rf_wa, 5 + i); end
      total++; if (rf_wd !== exp_t[i]) begin bad++; $display("FAIL ld_wd[%0d] got=%h exp=%h", i, rf_wd, exp_t[i]); end
    end
    ld_vld = 1'b0;
    tick();
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL idle_we got=%b exp=0", rf_we); end
    total++; if (rf_wa !== 5'd11 || rf_wd !== 32'h8899AABB) begin
      bad++; $display("FAIL idle_hold got=%0d/%h exp=11/8899aabb", rf_wa, rf_wd);
    end
  endtask

  task automatic test_alu();
    alu_vld = 1'b1; alu_rd = 5'd9; alu_data = 32'h12345678;
    #1;
    total++; if (alu_rdy !== 1'b1) begin bad++; $display("FAIL alu_rdy got=%b exp=1", alu_rdy); end
    total++; if (ld_rdy !== 1'b0) begin bad++; $display("FAIL alu_ldrdy got=%b exp=0", ld_rdy); end
    tick();
    alu_vld = 1'b0;
    total++; if (rf_we !== 1'b1 || rf_wa !== 5'd9 || rf_wd !== 32'h12345678) begin
      bad++; $display("FAIL alu_wb got=%b/%0d/%h exp=1/9/12345678", rf_we, rf_wa, rf_wd);
    end
    tick();
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL alu_pulse got=%b exp=0", rf_we); end
  endtask

  task automatic test_priority();
    logic exp_alu;
    alu_vld = 1'b1; alu_rd = 5'd20; alu_data = 32'hA5A5A5A5;
    ld_vld = 1'b1; ld_whb = 3'd0; ld_data = 32'h0BADF00D;
    for (int i = 0; i < 5; i++) begin
      ld_rd = 5'(10 + i);
      exp_alu = FAIR && (i == 3);
      #1;
      total++; if (alu_rdy !== exp_alu || ld_rdy !== !exp_alu) begin
        bad++; $display("FAIL prio_rdy[%0d] got=%b%b exp=%b%b", i, alu_rdy, ld_rdy, exp_alu, !exp_alu);
      end
      tick();
      total++; if (rf_wa !== (exp_alu ? 5'd20 : 5'(10 + i))) begin
        bad++; $display("FAIL prio_wa[%0d] got=%0d", i, rf_wa);
      end
    end
    alu_vld = 1'b0; ld_vld = 1'b0;
    tick();
  endtask

  task automatic test_scoreboard();
    issue_vld = 1'b1; issue_rd = 5'd7;
    tick();
    issue_vld = 1'b0; chk_rs = 5'd7; chk_rt = 5'd0;
    #1;
    total++; if (busy !== 32'h0000_0080) begin bad++; $display("FAIL sb_busy got=%h exp=00000080", busy); end
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL sb_stall_rs got=%b exp=1", stall); end
    chk_rs = 5'd3; chk_rt = 5'd7;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL sb_stall_rt got=%b exp=1", stall); end
    alu_vld = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
    tick();
    alu_vld = 1'b0;
    total++; if (rf_we !== 1'b1 || rf_wa !== 5'd7) begin bad++; $display("FAIL sb_wb got=%b/%0d exp=1/7", rf_we, rf_wa); end
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL sb_nobypass got=%b exp=1", stall); end
    tick();
    total++; if (stall !== 1'b0 || busy !== 32'h0) begin bad++; $display("FAIL sb_clear got=%b/%h exp=0/0", stall, busy); end
    // same-edge set and clear of r7
    issue_vld = 1'b1; issue_rd = 5'd7;
    tick();
    issue_vld = 1'b0;
    alu_vld = 1'b1;
    tick();
    alu_vld = 1'b0; issue_vld = 1'b1; issue_rd = 5'd7;
    tick();
    issue_vld = 1'b0;
    total++; if (busy[7] !== 1'b1) begin bad++; $display("FAIL sb_setwins got=%b exp=1", busy[7]); end
    tick();
    total++; if (busy !== 32'h0000_0080) begin bad++; $display("FAIL sb_hold got=%h exp=00000080", busy); end
    alu_vld = 1'b1;
    tick();
    alu_vld = 1'b0;
    tick();
    chk_rt = 5'd0;
  endtask

  task automatic test_rd_zero();
    issue_vld = 1'b1; issue_rd = 5'd3;
    tick();
    issue_vld = 1'b0;
    alu_vld = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEADBEEF;
    #1;
    total++; if (alu_rdy !== 1'b1) begin bad++; $display("FAIL rd0_rdy got=%b exp=1", alu_rdy); end
    tick();
    alu_vld = 1'b0;
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL rd0_we got=%b exp=0", rf_we); end
    issue_vld = 1'b1; issue_rd = 5'd0;
    tick();
    issue_vld = 1'b0;
    total++; if (busy !== 32'h0000_0008) begin bad++; $display("FAIL rd0_busy got=%h exp=00000008", busy); end
    alu_vld = 1'b1; alu_rd = 5'd3;
    tick();
    alu_vld = 1'b0;
    tick();
    total++; if (busy !== 32'h0) begin bad++; $display("FAIL rd0_clear got=%h exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    ld_vld = 1'b1; ld_rd = 5'd4; ld_whb = 3'd0; ld_data = 32'hCAFEBABE;
    issue_vld = 1'b1; issue_rd = 5'd9;
    tick();
    ld_vld = 1'b0; issue_vld = 1'b0;
    total++; if (rf_we !== 1'b1 || busy !== 32'h0000_0200) begin
      bad++; $display("FAIL rstmid_pre got=%b/%h exp=1/00000200", rf_we, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL rstmid_we got=%b exp=0", rf_we); end
    total++; if (busy !== 32'h0 || rf_wa !== 5'd0 || rf_wd !== 32'h0) begin
      bad++; $display("FAIL rstmid_state got=%h/%0d/%h exp=0/0/0", busy, rf_wa, rf_wd);
    end
    tick();
    rst_n = 1'b1;
    tick();
    total++; if (rf_we !== 1'b0 || busy !== 32'h0) begin bad++; $display("FAIL rstmid_after got=%b/%h exp=0/0", rf_we, busy); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_load_extract();
    test_alu();
    test_priority();
    test_scoreboard();
    test_rd_zero();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
